// File: rtl/shift_add_multiplier16_if.sv
// Request/result bundle for the sequential 16x16 shift-add multiplier.
interface shift_add_multiplier16_if;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        busy;
  logic        done;
  logic [31:0] P;

  // Requester side.
  modport master (output start, A, B, input busy, done, P);
  // Multiplier side.
  modport slave  (input start, A, B, output busy, done, P);
endinterface

// File: rtl/shift_add_multiplier16.sv
// Sequential 16x16 unsigned multiplier built around a 16-bit ripple adder.
// One add-and-shift per clock, 16 iterations, then a one-cycle done pulse.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; operands captured on acceptance
// RUN   | 16 add/shift iterations, busy high, P holds previous result
// DONE  | product registered on P, done high for one cycle

module rippleAdder16bit (
  input  logic [15:0] X,
  input  logic [15:0] Y,
  input  logic        Ci,
  output logic [15:0] S,
  output logic        Co
);
  logic [16:0] c;

  assign c[0] = Ci;

  // Chain of full adders; carry ripples from bit 0 to bit 15.
  for (genvar i = 0; i < 16; i++) begin : g_fa
    assign S[i]   = X[i] ^ Y[i] ^ c[i];
    assign c[i+1] = (X[i] & Y[i]) | (c[i] & (X[i] ^ Y[i]));
  end

  assign Co = c[16];
endmodule

module shift_add_multiplier16 (
  input  logic                     clk,
  input  logic                     rst_n,
  shift_add_multiplier16_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] areg_q, areg_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] mreg_q, mreg_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] p_q, p_d;

  logic [15:0] add_y;
  logic [15:0] add_s;
  logic        add_co;

  // Partial-product step: add the multiplicand when the current multiplier bit is set.
  assign add_y = mreg_q[0] ? areg_q : 16'h0000;

  rippleAdder16bit u_adder (
    .X  (acc_q),
    .Y  (add_y),
    .Ci (1'b0),
    .S  (add_s),
    .Co (add_co)
  );

  // Next-state and datapath update; the adder carry shifts into acc[15].
  always_comb begin
    state_d = state_q;
    areg_d  = areg_q;
    acc_d   = acc_q;
    mreg_d  = mreg_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          areg_d  = bus.A;
          acc_d   = 16'h0000;
          mreg_d  = bus.B;
          cnt_d   = 5'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d  = {add_co, add_s[15:1]};
        mreg_d = {add_s[0], mreg_q[15:1]};
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd15) begin
          p_d     = {add_co, add_s[15:1], add_s[0], mreg_q[15:1]};
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      areg_q  <= 16'h0000;
      acc_q   <= 16'h0000;
      mreg_q  <= 16'h0000;
      cnt_q   <= 5'd0;
      p_q     <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      areg_q  <= areg_d;
      acc_q   <= acc_d;
      mreg_q  <= mreg_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.P    = p_q;
endmodule

// File: tb/tb_shift_add_multiplier16.sv
// Self-checking bench for shift_add_multiplier16; products checked against a*b.
module tb_shift_add_multiplier16;
  logic clk;
  logic rst_n;
  int   total_cnt;
  int   pass_cnt;

  shift_add_multiplier16_if bus ();

  shift_add_multiplier16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    return 32'(a) * 32'(b);
  endfunction

  // Issue one request and follow it to done. lat = edges from acceptance to done
  // (-1 on timeout); p_ok = P held and busy high on every RUN cycle.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       output int lat, output logic [31:0] p, output bit p_ok);
    logic [31:0] p_before;
    @(negedge clk);
    p_before  = bus.P;
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.A     = $urandom;
    bus.B     = $urandom;
    lat  = -1;
    p_ok = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (bus.done) begin
        lat = k;
        break;
      end
      if (bus.P !== p_before || bus.busy !== 1'b1) p_ok = 1'b0;
      @(negedge clk);
    end
    p = bus.P;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.A     = 16'h0003;
    bus.B     = 16'h0005;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy);
    else pass_cnt++;
    total_cnt++;
    if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done);
    else pass_cnt++;
    total_cnt++;
    if (bus.P !== 32'h0) $display("FAIL reset_p: got %h want 00000000", bus.P);
    else pass_cnt++;
    bus.start = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL reset_release_idle: busy %b want 0", bus.busy);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int lat; logic [31:0] p; bit p_ok;
    do_op(16'd3, 16'd5, lat, p, p_ok);
    total_cnt++;
    if (lat !== 16) $display("FAIL basic_latency: got %0d want 16", lat);
    else pass_cnt++;
    total_cnt++;
    if (p !== 32'h0000000F) $display("FAIL basic_p: got %h want 0000000f", p);
    else pass_cnt++;
    total_cnt++;
    if (p_ok !== 1'b1) $display("FAIL basic_run_hold: P/busy disturbed during RUN got %b want 1", p_ok);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (bus.done !== 1'b0) $display("FAIL basic_done_pulse: done %b want 0 after one cycle", bus.done);
    else pass_cnt++;
  endtask

  task automatic test_corners();
    logic [15:0] av [5] = '{16'hFFFF, 16'h8000, 16'h1234, 16'h1234, 16'h0000};
    logic [15:0] bv [5] = '{16'hFFFF, 16'h0002, 16'h0000, 16'h0001, 16'hFFFF};
    logic [31:0] want [5] = '{32'hFFFE0001, 32'h00010000, 32'h0, 32'h00001234, 32'h0};
    int lat; logic [31:0] p; bit p_ok;
    for (int i = 0; i < 5; i++) begin
      do_op(av[i], bv[i], lat, p, p_ok);
      total_cnt++;
      if (p !== want[i] || p !== ref_mul(av[i], bv[i]) || lat !== 16)
        $display("FAIL corner_%0d: %h*%h got P=%h lat=%0d want P=%h lat=16",
                 i, av[i], bv[i], p, lat, want[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    int lat; logic [31:0] p; bit p_ok;
    logic [15:0] a, b;
    for (int i = 0; i < 24; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (i % 6 == 0) a = 16'hFFFF;
      do_op(a, b, lat, p, p_ok);
      total_cnt++;
      if (p !== ref_mul(a, b) || lat !== 16 || p_ok !== 1'b1)
        $display("FAIL random_%0d: %h*%h got P=%h lat=%0d hold=%b want P=%h lat=16 hold=1",
                 i, a, b, p, lat, p_ok, ref_mul(a, b));
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    int first_done, accept2, second_done, busy_in_done;
    logic [31:0] p1, p2;
    first_done = -1; accept2 = -1; second_done = -1; busy_in_done = -1;
    p1 = 'x; p2 = 'x;
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 16'd7;
    bus.B     = 16'd9;
    @(negedge clk);
    for (int k = 0; k < 45; k++) begin
      if (k == 3) begin
        bus.A = 16'd2;
        bus.B = 16'd2;
      end
      if (bus.done && first_done < 0) begin
        first_done   = k;
        p1           = bus.P;
        busy_in_done = int'(bus.busy);
      end else if (bus.done && first_done >= 0) begin
        second_done = k;
        p2          = bus.P;
        break;
      end
      if (bus.busy && first_done >= 0 && accept2 < 0) accept2 = k;
      @(negedge clk);
    end
    bus.start = 1'b0;
    total_cnt++;
    if (first_done !== 16) $display("FAIL b2b_first_latency: got %0d want 16", first_done);
    else pass_cnt++;
    total_cnt++;
    if (p1 !== 32'd63) $display("FAIL b2b_first_p: got %h want 0000003f", p1);
    else pass_cnt++;
    total_cnt++;
    if (busy_in_done !== 0) $display("FAIL b2b_busy_in_done: got %0d want 0", busy_in_done);
    else pass_cnt++;
    total_cnt++;
    if (accept2 !== 18) $display("FAIL b2b_second_accept: got %0d want 18", accept2);
    else pass_cnt++;
    total_cnt++;
    if (second_done !== 34) $display("FAIL b2b_second_latency: got %0d want 34", second_done);
    else pass_cnt++;
    total_cnt++;
    if (p2 !== 32'd4) $display("FAIL b2b_second_p: got %h want 00000004", p2);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    int lat; logic [31:0] p; bit p_ok; bit saw_done;
    do_op(16'd3, 16'd5, lat, p, p_ok);
    total_cnt++;
    if (p !== 32'd15) $display("FAIL midrst_pre_p: got %h want 0000000f", p);
    else pass_cnt++;
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 16'hFFFF;
    bus.B     = 16'hFFFF;
    @(negedge clk);
    bus.start = 1'b0;
    saw_done  = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.P !== 32'h0)
      $display("FAIL midrst_state: busy=%b done=%b P=%h want 0 0 00000000", bus.busy, bus.done, bus.P);
    else pass_cnt++;
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    total_cnt++;
    if (saw_done !== 1'b0 || bus.P !== 32'h0)
      $display("FAIL midrst_abandon: done_seen=%b P=%h want 0 00000000", saw_done, bus.P);
    else pass_cnt++;
    do_op(16'd2, 16'd3, lat, p, p_ok);
    total_cnt++;
    if (p !== 32'd6 || lat !== 16)
      $display("FAIL midrst_restart: P=%h lat=%0d want 00000006 lat=16", p, lat);
    else pass_cnt++;
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = 16'h0;
    bus.B     = 16'h0;
    test_reset();
    test_basic();
    test_corners();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
